// File: rtl/uart_cmd_ctrl_if.sv
// Byte-in / register-write-out bundle for the UART command controller.
// The controller takes the slave side; the byte source and register sink take the master side.
interface uart_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  modport slave (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, frame_err, err_cnt, busy
  );

  modport master (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, frame_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Decodes SYNC/ADDR/DATA/CHK byte frames from a UART receiver into single register writes,
// with an inter-byte timeout and a saturating error counter.
module uart_cmd_ctrl #(
  parameter int         CLOCK_FREQUENCY = 100_000_000,
  parameter int         BAUD_RATE       = 115200,
  parameter int         TIMEOUT_BYTES   = 4,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_ctrl_if.slave  bus
);

  localparam int TIMEOUT_CLKS = (CLOCK_FREQUENCY / BAUD_RATE) * 10 * TIMEOUT_BYTES;
  localparam int TW           = $clog2(TIMEOUT_CLKS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            expire;
  logic            bad;

  // Expiry fires on the edge where the counter would step onto TIMEOUT_CLKS-1, so the
  // error pulse lands TIMEOUT_CLKS-1 cycles after the last byte; a byte on that edge wins.
  assign expire = (state_q != S_IDLE) && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CLKS - 2));

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bad       = 1'b0;

    if (bus.rx_valid || state_q == S_IDLE) tmo_d = '0;
    else                                   tmo_d = tmo_q + TW'(1);

    unique case (state_q)
      S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR: if (bus.rx_valid) begin
        addr_d  = bus.rx_data;
        state_d = S_DATA;
      end
      S_DATA: if (bus.rx_valid) begin
        data_d  = bus.rx_data;
        state_d = S_CHK;
      end
      S_CHK: if (bus.rx_valid) begin
        if (bus.rx_data == (addr_q ^ data_q)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
        end else begin
          bad = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      bad     = 1'b1;
    end

    if (bad) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Random and directed byte streams into uart_cmd_ctrl, checked every cycle against a
// frame-level reference model (byte queue plus idle-gap count).
module tb_uart_cmd_ctrl;
  localparam int         CF   = 1_000_000;
  localparam int         BR   = 100_000;
  localparam int         TOB  = 2;
  localparam int         TC   = (CF / BR) * 10 * TOB;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(
    .CLOCK_FREQUENCY(CF),
    .BAUD_RATE      (BR),
    .TIMEOUT_BYTES  (TOB),
    .SYNC_BYTE      (SYNC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_fe  = 0;

  // reference model state
  logic [7:0] frm[$];
  int         m_gap;
  logic       m_wr, m_err;
  logic [7:0] m_waddr, m_wdata, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    frm.delete();
    m_gap = 0; m_wr = 0; m_err = 0;
    m_waddr = 0; m_wdata = 0; m_cnt = 0;
  endtask

  task automatic model_error();
    m_err = 1;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    m_wr = 0; m_err = 0;
    if (v) begin
      m_gap = 0;
      if (frm.size() != 0 || b == SYNC) frm.push_back(b);
      if (frm.size() == 4) begin
        if (frm[3] == (frm[1] ^ frm[2])) begin
          m_wr = 1; m_waddr = frm[1]; m_wdata = frm[2];
        end else model_error();
        frm.delete();
      end
    end else if (frm.size() != 0) begin
      m_gap++;
      if (m_gap == TC - 1) begin
        model_error();
        frm.delete();
        m_gap = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("wr_en",     bus.wr_en,     m_wr);
    chk("frame_err", bus.frame_err, m_err);
    chk("busy",      bus.busy,      frm.size() != 0);
    chk("err_cnt",   bus.err_cnt,   m_cnt);
    chk("wr_addr",   bus.wr_addr,   m_waddr);
    chk("wr_data",   bus.wr_data,   m_wdata);
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, check after.
  task automatic step(input logic v, input logic [7:0] b);
    bus.rx_valid = v;
    bus.rx_data  = v ? b : 8'($urandom);
    @(posedge clk);
    model_step(v, b);
    @(negedge clk);
    check_all();
    if (bus.wr_en)     n_wr++;
    if (bus.frame_err) n_fe++;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    chk("rst_wr_en",   bus.wr_en,     0);
    chk("rst_err",     bus.frame_err, 0);
    chk("rst_busy",    bus.busy,      0);
    chk("rst_err_cnt", bus.err_cnt,   0);
    chk("rst_wr_addr", bus.wr_addr,   0);
    chk("rst_wr_data", bus.wr_data,   0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_frame();
    int         kind;
    logic [7:0] a, d, c, x;
    kind = $urandom_range(0, 7);
    a = 8'($urandom); d = 8'($urandom);
    if (kind <= 3) begin
      send(SYNC, $urandom_range(0, 2)); send(a, $urandom_range(0, 2));
      send(d, $urandom_range(0, 2));    send(a ^ d, $urandom_range(0, 2));
    end else if (kind <= 5) begin
      x = 8'($urandom_range(1, 255));
      send(SYNC, $urandom_range(0, 2)); send(a, $urandom_range(0, 2));
      send(d, $urandom_range(0, 2));    send((a ^ d) ^ x, $urandom_range(0, 2));
    end else if (kind == 6) begin
      c = 8'($urandom);
      if (c == SYNC) c = 8'h00;
      send(c, $urandom_range(0, 2));
    end else begin
      send(SYNC, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) send(a, 0);
      idle(TC + $urandom_range(0, 3));
    end
  endtask

  initial begin
    int k, wr0, fe0;
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset_pulse();

    // good frame
    send(SYNC, 3); send(8'h12, 3); send(8'h34, 3); send(8'h26, 0);
    chk("good_wr_en", bus.wr_en, 1);
    chk("good_addr",  bus.wr_addr, 8'h12);
    chk("good_data",  bus.wr_data, 8'h34);
    idle(1);
    chk("good_wr_once", bus.wr_en, 0);
    chk("good_err_cnt", bus.err_cnt, 0);

    // bad checksum
    send(SYNC, 2); send(8'h12, 2); send(8'h34, 2); send(8'h00, 0);
    chk("bad_err",     bus.frame_err, 1);
    chk("bad_wr_en",   bus.wr_en, 0);
    chk("bad_err_cnt", bus.err_cnt, 1);
    chk("bad_addr",    bus.wr_addr, 8'h12);
    idle(2);

    // timeout latency
    send(SYNC, 1); send(8'h12, 0);
    k = 0;
    for (int i = 1; i <= TC + 10 && k == 0; i++) begin
      step(1'b0, 8'h00);
      if (bus.frame_err) k = i;
    end
    chk("tmo_latency", k, TC - 1);
    chk("tmo_busy",    bus.busy, 0);
    chk("tmo_err_cnt", bus.err_cnt, 2);
    idle(2);

    // leading junk ignored
    send(8'h00, 1); send(8'hFF, 1); send(SYNC, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    chk("junk_wr_en", bus.wr_en, 1);
    chk("junk_addr",  bus.wr_addr, 8'h01);
    chk("junk_data",  bus.wr_data, 8'h02);
    chk("junk_err_cnt", bus.err_cnt, 2);

    // bytes landing exactly on the expiry edge keep the frame alive
    send(SYNC, TC - 2); send(8'h40, TC - 2); send(8'h0F, TC - 2); send(8'h4F, 0);
    chk("race_wr_en", bus.wr_en, 1);
    chk("race_addr",  bus.wr_addr, 8'h40);
    chk("race_err_cnt", bus.err_cnt, 2);
    idle(1);

    // reset mid-frame
    wr0 = n_wr; fe0 = n_fe;
    send(SYNC, 1); send(8'h12, 1);
    reset_pulse();
    idle(3);
    chk("midrst_no_pulse", (n_wr - wr0) + (n_fe - fe0), 0);
    send(SYNC, 0); send(8'h77, 0); send(8'h88, 0); send(8'hFF, 0);
    chk("midrst_wr_en", bus.wr_en, 1);
    chk("midrst_addr",  bus.wr_addr, 8'h77);
    chk("midrst_data",  bus.wr_data, 8'h88);

    // randomized traffic
    for (int f = 0; f < 150; f++) random_frame();
    idle(TC);

    // saturation: 300 back-to-back bad frames
    fe0 = n_fe;
    for (int f = 0; f < 300; f++) begin
      logic [7:0] a, d;
      a = 8'($urandom); d = 8'($urandom);
      send(SYNC, 0); send(a, 0); send(d, 0); send(a ^ d ^ 8'h01, 0);
    end
    chk("sat_pulses",  n_fe - fe0, 300);
    chk("sat_err_cnt", bus.err_cnt, 8'hFF);
    send(SYNC, 0); send(8'h21, 0); send(8'h43, 0); send(8'h62, 0);
    chk("sat_good_wr", bus.wr_en, 1);
    chk("sat_hold",    bus.err_cnt, 8'hFF);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have the parameter CLOCK_FREQUENCY, default 100_000_000, giving the system clock in Hz.
REQ-002 The block SHALL have the parameter BAUD_RATE, default 115200, giving the UART bit rate.
REQ-003 The block SHALL have the parameter TIMEOUT_BYTES, default 4, giving the inter-byte timeout in character times of 10 bits each.
REQ-004 The block SHALL have the parameter SYNC_BYTE, default 8'hA5, giving the frame start marker.
REQ-005 The block SHALL derive the localparam TIMEOUT_CLKS = (CLOCK_FREQUENCY / BAUD_RATE) * 10 * TIMEOUT_BYTES.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 rx_valid  input  1  one-cycle strobe meaning a received byte is present on rx_data; driven by the UART receiver's byte-ready output.
REQ-009 rx_data  input  8  received byte, valid only while rx_valid=1.
REQ-010 wr_en  output  1  one-cycle register-write strobe.
REQ-011 wr_addr  output  8  register address of the last good frame.
REQ-012 wr_data  output  8  register data of the last good frame.
REQ-013 frame_err  output  1  one-cycle pulse on a checksum failure or a timeout.
REQ-014 err_cnt  output  8  count of frame errors, saturating.
REQ-015 busy  output  1  high while a frame is in progress (state is not IDLE).

Function
REQ-016 Frame format SHALL be four bytes, in order: SYNC_BYTE, ADDR, DATA, CHK, where CHK = ADDR xor DATA.
REQ-017 The FSM SHALL have the states IDLE, ADDR, DATA and CHK; every output is registered, except busy, which decodes the state directly.
REQ-018 IDLE: rx_valid with rx_data==SYNC_BYTE -> ADDR; any other byte is ignored, with no error and no count.
REQ-019 ADDR: on rx_valid, the block latches rx_data into an internal addr_q and moves to DATA; a value equal to SYNC_BYTE is treated as a valid address, with no resync.
REQ-020 DATA: on rx_valid, the block latches rx_data into an internal data_q and moves to CHK.
REQ-021 CHK: on rx_valid with rx_data==(addr_q xor data_q), the block asserts wr_en for exactly one cycle and loads wr_addr<=addr_q and wr_data<=data_q, in the cycle after the CHK byte strobe; it then returns to IDLE.
REQ-022 CHK: on rx_valid with a mismatch, the block pulses frame_err for one cycle after the strobe, increments err_cnt, and returns to IDLE; wr_addr and wr_data are left unchanged.
REQ-023 wr_addr and wr_data SHALL hold their values until the next good frame.
REQ-024 The timeout counter, of width $clog2(TIMEOUT_CLKS), SHALL be cleared on every rx_valid and held at 0 in IDLE; in the other states it SHALL increment by 1 per cycle.
REQ-025 When the timeout counter reaches TIMEOUT_CLKS-1 outside IDLE, the block SHALL go to IDLE, pulse frame_err for one cycle, and increment err_cnt.
REQ-026 If rx_valid and timeout expiry occur in the same cycle, rx_valid SHALL win: the byte is processed, the counter is cleared, and no timeout error occurs.
REQ-027 err_cnt SHALL saturate at 8'hFF, meaning further errors still pulse frame_err but do not wrap the count.
REQ-028 A frame_err pulse and a wr_en pulse SHALL never be asserted in the same cycle.
REQ-029 Back-to-back frames with no idle gap SHALL be accepted, with one wr_en per good frame.
REQ-030 The latency from the CHK strobe to wr_en SHALL be exactly 1 cycle.

Reset
REQ-031 On rst_n=0, the block SHALL immediately set state=IDLE, timeout counter=0, addr_q=data_q=0, wr_en=0, wr_addr=0, wr_data=0, frame_err=0 and err_cnt=0, so busy=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame with no wr_en and no frame_err; after release, the block waits for SYNC_BYTE.

Verification
REQ-033 Bytes A5,12,34,26 at one rx_valid per 868 clk -> a single wr_en pulse 1 cycle after the last strobe, with wr_addr=12 and wr_data=34; err_cnt stays 0.
REQ-034 Bytes A5,12,34,00 -> frame_err pulses once, err_cnt=1, no wr_en, wr_addr and wr_data unchanged.
REQ-035 Bytes A5,12 then silence -> frame_err exactly TIMEOUT_CLKS-1 cycles after the 12 strobe (34719 cycles at the defaults), busy falls, err_cnt=1.
REQ-036 Bytes 00,FF,A5,01,02,03 -> the leading bytes are ignored; wr_en fires with wr_addr=01 and wr_data=02.
REQ-037 300 bad-checksum frames -> err_cnt=FF and held there; frame_err still pulses on every error.
REQ-038 rst_n low for 1 cycle after A5,12 and before the DATA byte -> outputs return to their reset values, no pulses occur, and the next full valid frame is accepted.
